// File: rtl/cu_pkg.sv
// Shared definitions for the control sequencer: state encodings, opcodes and
// the Ctrl bit layout. Every execute sequence has contiguous state codes.
package cu_pkg;

  localparam int ST_W = 8;

  typedef enum logic [ST_W-1:0] {
    S_RESET, S_FETCH0, S_FETCH1, S_FETCH2, S_HALT,
    S_LD3, S_LD4, S_LD5, S_LD6, S_LD7,
    S_LDI3, S_LDI4, S_LDI5,
    S_ST3, S_ST4, S_ST5, S_ST6, S_ST7,
    S_ADD3, S_ADD4, S_ADD5, S_SUB3, S_SUB4, S_SUB5,
    S_SHR3, S_SHR4, S_SHR5, S_SHL3, S_SHL4, S_SHL5,
    S_ROR3, S_ROR4, S_ROR5, S_ROL3, S_ROL4, S_ROL5,
    S_AND3, S_AND4, S_AND5, S_OR3, S_OR4, S_OR5,
    S_ADDI3, S_ADDI4, S_ADDI5, S_ANDI3, S_ANDI4, S_ANDI5,
    S_ORI3, S_ORI4, S_ORI5,
    S_NEG3, S_NEG4, S_NEG5, S_NOT3, S_NOT4, S_NOT5,
    S_MUL3, S_MUL4, S_MUL5, S_MUL6, S_DIV3, S_DIV4, S_DIV5, S_DIV6,
    S_BR3, S_BR4, S_BR5, S_BR6, S_JR3, S_JAL3, S_JAL4,
    S_IN3, S_OUT3, S_MFHI3, S_MFLO3, S_NOP3
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110, OP_ROR  = 5'b00111, OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001, OP_OR   = 5'b01010, OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100, OP_ORI  = 5'b01101, OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111, OP_NEG  = 5'b10000, OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_BR   = 5'b10010, OP_JR   = 5'b10011, OP_JAL  = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10101, OP_OUT  = 5'b10110, OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000, OP_NOP  = 5'b11001, OP_HALT = 5'b11010;

  localparam int C_PC_OUT  = 0,  C_MAR_IN  = 1,  C_READ     = 2,  C_WRITE      = 3;
  localparam int C_MDR_IN  = 4,  C_MDR_OUT = 5,  C_IR_IN    = 6,  C_INC_PC     = 7;
  localparam int C_PC_IN   = 8,  C_R_OUT   = 9,  C_R_IN     = 10, C_GRA        = 11;
  localparam int C_GRB     = 12, C_GRC     = 13, C_BA_OUT   = 14, C_Y_IN       = 15;
  localparam int C_C_OUT   = 16, C_ZHI_IN  = 17, C_ZLO_IN   = 18, C_ZHI_OUT    = 19;
  localparam int C_ZLO_OUT = 20, C_HI_IN   = 21, C_LO_IN    = 22, C_HI_OUT     = 23;
  localparam int C_LO_OUT  = 24, C_INPORT_OUT = 25, C_OUTPORT_IN = 26, C_CON_IN = 27;
  localparam int C_ADD = 28, C_SUB = 29, C_SHR = 30, C_SHL = 31, C_ROR = 32, C_ROL = 33;
  localparam int C_AND = 34, C_OR  = 35, C_MUL = 36, C_DIV = 37, C_NEG = 38, C_NOT = 39;
  localparam int CTRL_W = 40;

  // First execute state for a legal opcode; halt maps straight to S_HALT.
  function automatic state_t exec_start(input logic [4:0] op);
    state_t s;
    s = S_HALT;
    case (op)
      OP_LD:   s = S_LD3;   OP_LDI:  s = S_LDI3;  OP_ST:   s = S_ST3;
      OP_ADD:  s = S_ADD3;  OP_SUB:  s = S_SUB3;  OP_SHR:  s = S_SHR3;
      OP_SHL:  s = S_SHL3;  OP_ROR:  s = S_ROR3;  OP_ROL:  s = S_ROL3;
      OP_AND:  s = S_AND3;  OP_OR:   s = S_OR3;   OP_ADDI: s = S_ADDI3;
      OP_ANDI: s = S_ANDI3; OP_ORI:  s = S_ORI3;  OP_MUL:  s = S_MUL3;
      OP_DIV:  s = S_DIV3;  OP_NEG:  s = S_NEG3;  OP_NOT:  s = S_NOT3;
      OP_BR:   s = S_BR3;   OP_JR:   s = S_JR3;   OP_JAL:  s = S_JAL3;
      OP_IN:   s = S_IN3;   OP_OUT:  s = S_OUT3;  OP_MFHI: s = S_MFHI3;
      OP_MFLO: s = S_MFLO3; OP_NOP:  s = S_NOP3;
      default: s = S_HALT;
    endcase
    return s;
  endfunction

  function automatic logic is_last(input state_t s);
    case (s)
      S_LD7, S_LDI5, S_ST7, S_ADD5, S_SUB5, S_SHR5, S_SHL5, S_ROR5, S_ROL5,
      S_AND5, S_OR5, S_ADDI5, S_ANDI5, S_ORI5, S_NEG5, S_NOT5, S_MUL6, S_DIV6,
      S_BR6, S_JR3, S_JAL4, S_IN3, S_OUT3, S_MFHI3, S_MFLO3, S_NOP3: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cu_ctrl_decode.sv
// Combinational State -> Ctrl decoder. Only the branch-commit state looks at
// the condition flag; the MUL/DIV issue state also sees its final-cycle flag.
module cu_ctrl_decode import cu_pkg::*; (
  input  logic [ST_W-1:0]   state_i,
  input  logic              con_ff_i,
  input  logic              mdiv_last_i,
  output logic [CTRL_W-1:0] ctrl_o
);

  state_t st;
  assign st = state_t'(state_i);

  always_comb begin
    ctrl_o = '0;
    case (st)
      S_FETCH0: begin ctrl_o[C_PC_OUT] = 1'b1; ctrl_o[C_MAR_IN] = 1'b1; end
      S_FETCH1, S_LD6: begin ctrl_o[C_READ] = 1'b1; ctrl_o[C_MDR_IN] = 1'b1; end
      S_FETCH2: begin
        ctrl_o[C_MDR_OUT] = 1'b1; ctrl_o[C_IR_IN] = 1'b1; ctrl_o[C_INC_PC] = 1'b1;
      end
      S_LD3, S_LDI3, S_ST3: begin
        ctrl_o[C_GRB] = 1'b1; ctrl_o[C_BA_OUT] = 1'b1; ctrl_o[C_Y_IN] = 1'b1;
      end
      S_LD4, S_LDI4, S_ST4, S_BR5: begin
        ctrl_o[C_C_OUT] = 1'b1; ctrl_o[C_ADD] = 1'b1; ctrl_o[C_ZLO_IN] = 1'b1;
      end
      S_LD5, S_ST5: begin ctrl_o[C_ZLO_OUT] = 1'b1; ctrl_o[C_MAR_IN] = 1'b1; end
      S_LD7: begin ctrl_o[C_MDR_OUT] = 1'b1; ctrl_o[C_GRA] = 1'b1; ctrl_o[C_R_IN] = 1'b1; end
      S_ST6: begin ctrl_o[C_GRA] = 1'b1; ctrl_o[C_R_OUT] = 1'b1; ctrl_o[C_MDR_IN] = 1'b1; end
      S_ST7: ctrl_o[C_WRITE] = 1'b1;
      S_ADD3, S_SUB3, S_SHR3, S_SHL3, S_ROR3, S_ROL3, S_AND3, S_OR3,
      S_ADDI3, S_ANDI3, S_ORI3, S_NEG3, S_NOT3: begin
        ctrl_o[C_GRB] = 1'b1; ctrl_o[C_R_OUT] = 1'b1; ctrl_o[C_Y_IN] = 1'b1;
      end
      S_ADD4, S_SUB4, S_SHR4, S_SHL4, S_ROR4, S_ROL4, S_AND4, S_OR4: begin
        ctrl_o[C_GRC] = 1'b1; ctrl_o[C_R_OUT] = 1'b1; ctrl_o[C_ZLO_IN] = 1'b1;
      end
      S_ADDI4, S_ANDI4, S_ORI4: begin ctrl_o[C_C_OUT] = 1'b1; ctrl_o[C_ZLO_IN] = 1'b1; end
      S_NEG4, S_NOT4: ctrl_o[C_ZLO_IN] = 1'b1;
      S_ADD5, S_SUB5, S_SHR5, S_SHL5, S_ROR5, S_ROL5, S_AND5, S_OR5,
      S_ADDI5, S_ANDI5, S_ORI5, S_NEG5, S_NOT5, S_LDI5: begin
        ctrl_o[C_ZLO_OUT] = 1'b1; ctrl_o[C_GRA] = 1'b1; ctrl_o[C_R_IN] = 1'b1;
      end
      S_MUL3, S_DIV3: begin ctrl_o[C_GRA] = 1'b1; ctrl_o[C_R_OUT] = 1'b1; ctrl_o[C_Y_IN] = 1'b1; end
      // The 64-bit product/quotient is captured only once the unit has settled.
      S_MUL4, S_DIV4: begin
        ctrl_o[C_GRB] = 1'b1; ctrl_o[C_R_OUT] = 1'b1;
        ctrl_o[C_ZHI_IN] = mdiv_last_i; ctrl_o[C_ZLO_IN] = mdiv_last_i;
      end
      S_MUL5, S_DIV5: begin ctrl_o[C_ZLO_OUT] = 1'b1; ctrl_o[C_LO_IN] = 1'b1; end
      S_MUL6, S_DIV6: begin ctrl_o[C_ZHI_OUT] = 1'b1; ctrl_o[C_HI_IN] = 1'b1; end
      S_BR3: begin ctrl_o[C_GRA] = 1'b1; ctrl_o[C_R_OUT] = 1'b1; ctrl_o[C_CON_IN] = 1'b1; end
      S_BR4: begin ctrl_o[C_PC_OUT] = 1'b1; ctrl_o[C_Y_IN] = 1'b1; end
      S_BR6: begin ctrl_o[C_ZLO_OUT] = con_ff_i; ctrl_o[C_PC_IN] = con_ff_i; end
      S_JR3, S_JAL4: begin ctrl_o[C_GRA] = 1'b1; ctrl_o[C_R_OUT] = 1'b1; ctrl_o[C_PC_IN] = 1'b1; end
      S_JAL3: begin ctrl_o[C_PC_OUT] = 1'b1; ctrl_o[C_GRB] = 1'b1; ctrl_o[C_R_IN] = 1'b1; end
      S_IN3: begin ctrl_o[C_INPORT_OUT] = 1'b1; ctrl_o[C_GRA] = 1'b1; ctrl_o[C_R_IN] = 1'b1; end
      S_OUT3: begin ctrl_o[C_GRA] = 1'b1; ctrl_o[C_R_OUT] = 1'b1; ctrl_o[C_OUTPORT_IN] = 1'b1; end
      S_MFHI3: begin ctrl_o[C_HI_OUT] = 1'b1; ctrl_o[C_GRA] = 1'b1; ctrl_o[C_R_IN] = 1'b1; end
      S_MFLO3: begin ctrl_o[C_LO_OUT] = 1'b1; ctrl_o[C_GRA] = 1'b1; ctrl_o[C_R_IN] = 1'b1; end
      default: ctrl_o = '0;
    endcase

    case (st)
      S_ADD4, S_ADDI4: ctrl_o[C_ADD] = 1'b1;
      S_SUB4:          ctrl_o[C_SUB] = 1'b1;
      S_SHR4:          ctrl_o[C_SHR] = 1'b1;
      S_SHL4:          ctrl_o[C_SHL] = 1'b1;
      S_ROR4:          ctrl_o[C_ROR] = 1'b1;
      S_ROL4:          ctrl_o[C_ROL] = 1'b1;
      S_AND4, S_ANDI4: ctrl_o[C_AND] = 1'b1;
      S_OR4, S_ORI4:   ctrl_o[C_OR]  = 1'b1;
      S_MUL4:          ctrl_o[C_MUL] = 1'b1;
      S_DIV4:          ctrl_o[C_DIV] = 1'b1;
      S_NEG4:          ctrl_o[C_NEG] = 1'b1;
      S_NOT4:          ctrl_o[C_NOT] = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired CPU control sequencer: fetch/execute state machine, stop latch and
// sticky Illegal flag. Define CONTROL_SEQUENCER_MEMWAIT_EN for Mem_Ready waits.
module control_sequencer import cu_pkg::*; #(
  parameter int DATA_W   = 32,
  parameter int OPC_W    = 5,   // must be at least 5
  parameter int STATE_W  = 8,
  parameter int MDIV_LAT = 3    // 0..15
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Stop,
  input  logic [DATA_W-1:0]  IR_Data,
  input  logic               ConFF_Out,
  input  logic               Mem_Ready,
  output logic               Run,
  output logic               Illegal,
  output logic [CTRL_W-1:0]  Ctrl,
  output logic [STATE_W-1:0] State
);

  localparam logic [3:0] LAT = 4'(MDIV_LAT);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       stop_q, stop_d;
  logic       illegal_q, illegal_d;

  logic [OPC_W-1:0] opc;
  logic             opc_legal;
  logic             is_mdiv, mdiv_last, mem_wait;
  logic             unused_ir;

  assign opc       = IR_Data[DATA_W-1 -: OPC_W];
  assign opc_legal = (opc <= OPC_W'(OP_HALT));
  assign unused_ir = ^IR_Data[DATA_W-OPC_W-1:0];

  assign is_mdiv   = (state_q == S_MUL4) || (state_q == S_DIV4);
  assign mdiv_last = (cnt_q == LAT);

`ifdef CONTROL_SEQUENCER_MEMWAIT_EN
  assign mem_wait = !Mem_Ready &&
                    ((state_q == S_FETCH1) || (state_q == S_LD6) || (state_q == S_ST7));
`else
  logic unused_mem_ready;
  assign unused_mem_ready = Mem_Ready;
  assign mem_wait = 1'b0;
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_RESET;
      cnt_q     <= '0;
      stop_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stop_q    <= stop_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
    stop_d    = stop_q | Stop;
    case (state_q)
      S_RESET: state_d = S_FETCH0;
      S_HALT:  state_d = S_HALT;
      S_FETCH2: begin
        if (opc_legal) begin
          state_d = exec_start(opc[4:0]);
        end else begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end
      end
      default: begin
        if (mem_wait) begin
          state_d = state_q;
        end else if (is_mdiv && !mdiv_last) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          cnt_d = '0;
          // A stop seen on this very edge still counts at the boundary.
          if (is_last(state_q)) state_d = stop_d ? S_HALT : S_FETCH0;
          else                  state_d = state_t'(ST_W'(state_q) + ST_W'(1));
        end
      end
    endcase
  end

  cu_ctrl_decode u_decode (
    .state_i     (state_q),
    .con_ff_i    (ConFF_Out),
    .mdiv_last_i (mdiv_last),
    .ctrl_o      (Ctrl)
  );

  assign State   = STATE_W'(state_q);
  assign Run     = !Reset && (state_q != S_HALT);
  assign Illegal = illegal_q;

endmodule
